// File: rtl/kpu_pkg.sv
// Shared types and encodings for the bus sequencer.
// State enum, operation kinds and register-select codes.
package kpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_EXEC,
    S_FIN
  } state_t;

  localparam logic [1:0] KIND_BIN = 2'b00;
  localparam logic [1:0] KIND_SHF = 2'b01;
  localparam logic [1:0] KIND_UN  = 2'b10;
  localparam logic [1:0] KIND_RSV = 2'b11;

  localparam logic [1:0] SEL_SRC0 = 2'd0;
  localparam logic [1:0] SEL_SRC1 = 2'd1;
  localparam logic [1:0] SEL_DST  = 2'd2;

  function automatic logic kind_legal(
    input logic [1:0] kind,
    input logic       shf_en
  );
    return (kind == KIND_BIN) ||
           (kind == KIND_UN)  ||
           (shf_en && kind == KIND_SHF);
  endfunction

endpackage

// File: rtl/bus_drive_decode.sv
// Combinational bus strobe decoder.
// Maps sequencer state, latched kind and WB to strobes.
module bus_drive_decode
  import kpu_pkg::*;
(
  input  state_t     state,
  input  logic [1:0] kind,
  input  logic       wb,
  output logic [1:0] reg_sel,
  output logic       reg_n_oe,
  output logic       reg_n_we,
  output logic       tmp0_n_we,
  output logic       tmp1_n_we,
  output logic       mlu_n_oe,
  output logic       shifter_n_oe,
  output logic       busy,
  output logic       done
);

  // Strobes idle high; each state pulls down only its own.
  always_comb begin
    reg_sel      = SEL_SRC0;
    reg_n_oe     = 1'b1;
    reg_n_we     = 1'b1;
    tmp0_n_we    = 1'b1;
    tmp1_n_we    = 1'b1;
    mlu_n_oe     = 1'b1;
    shifter_n_oe = 1'b1;
    done         = 1'b0;
    busy         = (state != S_IDLE);
    unique case (state)
      S_IDLE: ;
      S_RD0: begin
        reg_sel   = SEL_SRC0;
        reg_n_oe  = 1'b0;
        tmp0_n_we = 1'b0;
      end
      S_RD1: begin
        reg_sel   = SEL_SRC1;
        reg_n_oe  = 1'b0;
        tmp1_n_we = 1'b0;
      end
      S_EXEC: begin
        reg_sel  = SEL_DST;
        reg_n_we = ~wb;
        if (kind == KIND_SHF)
          shifter_n_oe = 1'b0;
        else
          mlu_n_oe = 1'b0;
      end
      S_FIN: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_sequencer.sv
// Bus micro-sequencer: IDLE -> RD0 -> [RD1] -> EXEC -> FIN.
// Define SHIFTER_EN to enable the shifter kind (01).
module bus_sequencer
  import kpu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [1:0] OP_KIND,
  input  logic [2:0] MLU_OP_IN,
  input  logic [1:0] SHIFT_OP_IN,
  input  logic       WB,
  input  logic [2:0] FLAGS_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ILLEGAL,
  output logic [1:0] REG_SEL,
  output logic       REG_N_OE,
  output logic       REG_N_WE,
  output logic       TMP0_N_WE,
  output logic       TMP1_N_WE,
  output logic       MLU_N_OE,
  output logic       SHIFTER_N_OE,
  output logic [2:0] MLU_OP,
  output logic [1:0] SHIFTER_OP,
  output logic [2:0] FLAGS
);

`ifdef SHIFTER_EN
  localparam logic SHF_EN = 1'b1;
`else
  localparam logic SHF_EN = 1'b0;
`endif

  state_t     state_q;
  state_t     state_d;
  logic [1:0] kind_q;
  logic       wb_q;
  logic [2:0] mop_q;
  logic [1:0] sop_q;
  logic [2:0] flags_q;
  logic       ill_q;
  logic       legal;
  logic       accept;
  logic       reject;
  logic       shf_n_oe;

  assign legal  = kind_legal(OP_KIND, SHF_EN);
  assign accept = (state_q == S_IDLE) && START && legal;
  assign reject = (state_q == S_IDLE) && START && !legal;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state: unary skips the second operand read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RD0;
      S_RD0:  state_d = (kind_q == KIND_UN) ? S_EXEC : S_RD1;
      S_RD1:  state_d = S_EXEC;
      S_EXEC: state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operation latches, flag capture and reject pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      kind_q  <= KIND_BIN;
      wb_q    <= 1'b0;
      mop_q   <= '0;
      sop_q   <= '0;
      flags_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      ill_q <= reject;
      if (accept) begin
        kind_q <= OP_KIND;
        wb_q   <= WB;
        mop_q  <= MLU_OP_IN;
        sop_q  <= SHIFT_OP_IN;
      end
      if (state_q == S_EXEC && kind_q != KIND_SHF)
        flags_q <= FLAGS_IN;
    end
  end

  bus_drive_decode u_dec (
    .state        (state_q),
    .kind         (kind_q),
    .wb           (wb_q),
    .reg_sel      (REG_SEL),
    .reg_n_oe     (REG_N_OE),
    .reg_n_we     (REG_N_WE),
    .tmp0_n_we    (TMP0_N_WE),
    .tmp1_n_we    (TMP1_N_WE),
    .mlu_n_oe     (MLU_N_OE),
    .shifter_n_oe (shf_n_oe),
    .busy         (BUSY),
    .done         (DONE)
  );

  assign ILLEGAL = ill_q;
  assign MLU_OP  = mop_q;
  assign FLAGS   = flags_q;

`ifdef SHIFTER_EN
  assign SHIFTER_N_OE = shf_n_oe;
  assign SHIFTER_OP   = sop_q;
`else
  logic unused_shf;
  assign unused_shf   = shf_n_oe ^ (^sop_q);
  assign SHIFTER_N_OE = 1'b1;
  assign SHIFTER_OP   = 2'b00;
`endif

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: vector table, corner sequences,
// and random traffic against a phase-queue model.
module tb_bus_sequencer;

`ifdef SHIFTER_EN
  localparam bit SHF = 1'b1;
`else
  localparam bit SHF = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, START, WB;
  logic [1:0] OP_KIND, SHIFT_OP_IN;
  logic [2:0] MLU_OP_IN, FLAGS_IN;
  logic       BUSY, DONE, ILLEGAL;
  logic [1:0] REG_SEL;
  logic       REG_N_OE, REG_N_WE, TMP0_N_WE, TMP1_N_WE;
  logic       MLU_N_OE, SHIFTER_N_OE;
  logic [2:0] MLU_OP, FLAGS;
  logic [1:0] SHIFTER_OP;

  bus_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .OP_KIND(OP_KIND),
    .MLU_OP_IN(MLU_OP_IN), .SHIFT_OP_IN(SHIFT_OP_IN),
    .WB(WB), .FLAGS_IN(FLAGS_IN), .BUSY(BUSY), .DONE(DONE),
    .ILLEGAL(ILLEGAL), .REG_SEL(REG_SEL), .REG_N_OE(REG_N_OE),
    .REG_N_WE(REG_N_WE), .TMP0_N_WE(TMP0_N_WE),
    .TMP1_N_WE(TMP1_N_WE), .MLU_N_OE(MLU_N_OE),
    .SHIFTER_N_OE(SHIFTER_N_OE), .MLU_OP(MLU_OP),
    .SHIFTER_OP(SHIFTER_OP), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s,
                       input logic [1:0] k, input logic [2:0] m,
                       input logic [1:0] so, input logic w,
                       input logic [2:0] f);
    RST = r; START = s; OP_KIND = k; MLU_OP_IN = m;
    SHIFT_OP_IN = so; WB = w; FLAGS_IN = f;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [5:0] strb;
  logic [2:0] ctl;
  logic [18:0] obs;
  assign strb = {REG_N_OE, REG_N_WE, TMP0_N_WE, TMP1_N_WE,
                 MLU_N_OE, SHIFTER_N_OE};
  assign ctl  = {BUSY, DONE, ILLEGAL};
  assign obs  = {ctl, REG_SEL, strb, MLU_OP, SHIFTER_OP, FLAGS};

  typedef struct {
    logic       rst, start;
    logic [1:0] kind;
    logic [2:0] mop;
    logic [1:0] sop;
    logic       wb;
    logic [2:0] fin;
    logic [2:0] e_ctl;
    logic [1:0] e_sel;
    logic [5:0] e_strb;
    logic [2:0] e_mop;
    logic [2:0] e_flags;
  } vec_t;

  vec_t tbl[17];

  // Reference model: pending bus phases of the current op.
  // 0 = read src0, 1 = read src1, 2 = execute, 3 = finish.
  int         q[$];
  logic [1:0] mk, ms;
  logic       mw, mi;
  logic [2:0] mm, mf;

  function automatic bit legal_kind(input logic [1:0] k);
    return k == 2'b00 || k == 2'b10 || (SHF && k == 2'b01);
  endfunction

  function automatic logic [18:0] model_out();
    logic [2:0] c;
    logic [1:0] sel;
    logic [5:0] s;
    c = {1'b0, 1'b0, mi};
    sel = 2'd0;
    s = 6'b111111;
    if (q.size() > 0) begin
      c = 3'b100;
      case (q[0])
        0: begin sel = 2'd0; s = 6'b010111; end
        1: begin sel = 2'd1; s = 6'b011011; end
        2: begin
          sel = 2'd2;
          s = {1'b1, ~mw, 2'b11,
               (mk == 2'b01) ? 2'b10 : 2'b01};
        end
        default: c = 3'b110;
      endcase
    end
    return {c, sel, s, mm, ms, mf};
  endfunction

  task automatic model_step(input logic r, input logic s,
                            input logic [1:0] k, input logic [2:0] m,
                            input logic [1:0] so, input logic w,
                            input logic [2:0] f);
    if (r) begin
      q.delete();
      mk = 0; mw = 0; mm = 0; ms = 0; mf = 0; mi = 0;
    end else if (q.size() == 0) begin
      mi = 0;
      if (s && legal_kind(k)) begin
        mk = k; mw = w; mm = m;
        ms = SHF ? so : 2'b00;
        if (k == 2'b10) q = '{0, 2, 3};
        else q = '{0, 1, 2, 3};
      end else if (s) begin
        mi = 1;
      end
    end else begin
      mi = 0;
      if (q[0] == 2 && mk != 2'b01) mf = f;
      void'(q.pop_front());
    end
  endtask

  initial begin
    logic       r_rst, r_st, r_wb;
    logic [1:0] r_k, r_so;
    logic [2:0] r_m, r_f;
    int lows;

    // rst start kind mop sop wb fin | ctl sel strb mop flags
    tbl[0]  = '{1,0,0,0,0,0,0, 3'b000,0,6'b111111,0,0};
    tbl[1]  = '{0,1,0,3,0,1,5, 3'b100,0,6'b010111,3,0};
    tbl[2]  = '{0,0,2,5,1,0,5, 3'b100,1,6'b011011,3,0};
    tbl[3]  = '{0,1,3,7,2,0,5, 3'b100,2,6'b101101,3,0};
    tbl[4]  = '{0,0,0,0,0,0,5, 3'b110,0,6'b111111,3,5};
    tbl[5]  = '{0,0,0,0,0,0,0, 3'b000,0,6'b111111,3,5};
    tbl[6]  = '{0,1,2,6,0,0,7, 3'b100,0,6'b010111,6,5};
    tbl[7]  = '{0,1,2,1,0,1,7, 3'b100,2,6'b111101,6,5};
    tbl[8]  = '{0,0,0,0,0,0,2, 3'b110,0,6'b111111,6,2};
    tbl[9]  = '{0,0,0,0,0,0,0, 3'b000,0,6'b111111,6,2};
    tbl[10] = '{0,1,3,4,0,1,0, 3'b001,0,6'b111111,6,2};
    tbl[11] = '{0,0,3,4,0,1,0, 3'b000,0,6'b111111,6,2};
    tbl[12] = '{0,1,0,1,0,1,0, 3'b100,0,6'b010111,1,2};
    tbl[13] = '{0,0,0,0,0,1,0, 3'b100,1,6'b011011,1,2};
    tbl[14] = '{1,0,0,0,0,0,0, 3'b000,0,6'b111111,0,0};
    tbl[15] = '{0,0,0,0,0,0,0, 3'b000,0,6'b111111,0,0};
    tbl[16] = '{1,1,0,7,0,1,0, 3'b000,0,6'b111111,0,0};

    drive(1, 0, 0, 0, 0, 0, 0);
    step();

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].kind, tbl[i].mop,
            tbl[i].sop, tbl[i].wb, tbl[i].fin);
      step();
      chk($sformatf("v%0d_ctl", i), ctl, tbl[i].e_ctl);
      chk($sformatf("v%0d_sel", i), REG_SEL, tbl[i].e_sel);
      chk($sformatf("v%0d_strb", i), strb, tbl[i].e_strb);
      chk($sformatf("v%0d_mop", i), MLU_OP, tbl[i].e_mop);
      chk($sformatf("v%0d_flags", i), FLAGS, tbl[i].e_flags);
    end

`ifdef SHIFTER_EN
    drive(0, 1, 1, 0, 2, 1, 7);
    step();
    chk("b2b_rd0_busy", BUSY, 1);
    chk("b2b_rd0_sop", SHIFTER_OP, 2);
    SHIFT_OP_IN = 1;
    step();
    chk("b2b_rd1_sop", SHIFTER_OP, 2);
    step();
    chk("b2b_exec_soe", SHIFTER_N_OE, 0);
    chk("b2b_exec_moe", MLU_N_OE, 1);
    chk("b2b_exec_we", REG_N_WE, 0);
    step();
    chk("b2b_fin_done", DONE, 1);
    chk("b2b_fin_flags", FLAGS, 0);
    step();
    chk("b2b_idle_busy", BUSY, 0);
    step();
    chk("b2b_2nd_busy", BUSY, 1);
    chk("b2b_2nd_sop", SHIFTER_OP, 1);
    START = 0;
    step(); step(); step();
    chk("b2b_2nd_done", DONE, 1);
    step();
    chk("b2b_end_busy", BUSY, 0);
`else
    drive(0, 1, 1, 0, 2, 1, 7);
    step();
    chk("shf_off_ill", ILLEGAL, 1);
    chk("shf_off_busy", BUSY, 0);
    step();
    chk("shf_off_sop", SHIFTER_OP, 0);
    chk("shf_off_strb", strb, 6'b111111);
    START = 0;
    step();
    chk("shf_off_ill_end", ILLEGAL, 0);
`endif

    drive(1, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0);
    step();
    for (int c = 0; c < 10000; c++) begin
      chk("rand_out", obs, model_out());
      lows = int'(!REG_N_OE) + int'(!MLU_N_OE) + int'(!SHIFTER_N_OE);
      chk("inv_one_oe", int'(lows <= 1), 1);
      chk("inv_oe_we", int'(!(!REG_N_OE && !REG_N_WE)), 1);
      r_rst = ($urandom_range(0, 39) == 0);
      r_st  = $urandom_range(0, 1) == 1;
      r_k   = 2'($urandom_range(0, 3));
      r_m   = 3'($urandom_range(0, 7));
      r_so  = 2'($urandom_range(0, 3));
      r_wb  = $urandom_range(0, 1) == 1;
      r_f   = 3'($urandom_range(0, 7));
      drive(r_rst, r_st, r_k, r_m, r_so, r_wb, r_f);
      model_step(r_rst, r_st, r_k, r_m, r_so, r_wb, r_f);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameter: none; all widths fixed (bus-control only, no data path through this block).
REQ-002 Port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  in  1  synchronous, active-high reset.
REQ-004 Port: START  in  1  request one micro-sequence; sampled only in IDLE.
REQ-005 Port: OP_KIND  in  2  00 MLU binary, 01 shifter, 10 MLU unary, 11 reserved.
REQ-006 Port: MLU_OP_IN  in  3 / SHIFT_OP_IN  in  2  unit opcode; latched at accept.
REQ-007 Port: WB  in  1  write result to register file; latched at accept.
REQ-008 Port: FLAGS_IN  in  3  MLU {N,C,Z}.
REQ-009 Port: BUSY  out  1  high in any non-IDLE state.
REQ-010 Port: DONE  out  1  one-cycle pulse on sequence completion.
REQ-011 Port: ILLEGAL  out  1  one-cycle pulse on rejected OP_KIND.
REQ-012 Port: REG_SEL  out  2  0 src0, 1 src1, 2 destination (src2).
REQ-013 Port: REG_N_OE, REG_N_WE, TMP0_N_WE, TMP1_N_WE, MLU_N_OE, SHIFTER_N_OE  out  1 each  active-low strobes.
REQ-014 Port: MLU_OP  out  3 / SHIFTER_OP  out  2  latched opcode to units.
REQ-015 Port: FLAGS  out  3  flags captured from last MLU EXEC.

Function
REQ-016 States IDLE, RD0, RD1, EXEC, FIN; FIN lasts exactly one cycle.
REQ-017 IDLE: all active-low strobes high, REG_SEL=0; START=1 with legal kind -> latch OP_KIND/opcodes/WB, go RD0.
REQ-018 RD0: REG_SEL=0, REG_N_OE=0, TMP0_N_WE=0; next RD1 for kinds 00/01, EXEC for 10.
REQ-019 RD1: REG_SEL=1, REG_N_OE=0, TMP1_N_WE=0; next EXEC.
REQ-020 EXEC: MLU_N_OE=0 (kinds 00/10) or SHIFTER_N_OE=0 (01); REG_SEL=2; REG_N_WE=0 iff latched WB; REG_N_OE=1; next FIN.
REQ-021 EXEC with MLU kind: FLAGS <= FLAGS_IN at end of cycle; shifter kind leaves FLAGS unchanged.
REQ-022 FIN: DONE=1, all strobes high; next IDLE; START in FIN ignored.
REQ-023 Latency: START accepted at cycle t -> DONE at t+4 (binary/shift), t+3 (unary); back-to-back throughput one op per 5/4 cycles.
REQ-024 START with OP_KIND=11 in IDLE: ILLEGAL=1 next cycle, state stays IDLE, no strobe asserted, latches unchanged.
REQ-025 START while BUSY ignored; input changes after accept have no effect.
REQ-026 Invariant every cycle: at most one of REG_N_OE, MLU_N_OE, SHIFTER_N_OE low; REG_N_OE and REG_N_WE never both low.

Reset
REQ-027 RST=1 at any edge, including mid-sequence: state IDLE, all strobes high, REG_SEL=0, BUSY/DONE/ILLEGAL 0, FLAGS 0, MLU_OP 0, SHIFTER_OP 0; aborted sequence emits no DONE.
REQ-028 RST dominates START in the same cycle.

Configuration
REQ-029 Macro SHIFTER_EN defined: kind 01 behaves per REQ-019/020.
REQ-030 SHIFTER_EN undefined: kind 01 treated as reserved (REQ-024), SHIFTER_N_OE tied 1, SHIFTER_OP tied 0.

Structure
REQ-031 Shared package kpu_pkg: state enum, OP_KIND constants, REG_SEL encodings (SRC0/SRC1/DST).
REQ-032 One sub-module bus_drive_decode: combinational state+kind+WB -> strobes/REG_SEL; sequencer holds only state and latches.

Verification
REQ-033 Binary MLU: START, kind 00, MLU_OP_IN=3, WB=1, FLAGS_IN=101 -> RD0,RD1,EXEC,FIN; REG_N_WE low only in EXEC; FLAGS=101; DONE at t+4.
REQ-034 Unary: kind 10, WB=0 -> RD1 skipped, REG_N_WE never low, DONE at t+3.
REQ-035 Illegal: kind 11 -> ILLEGAL pulse at t+1, BUSY stays 0; with SHIFTER_EN undefined, kind 01 same result.
REQ-036 Reset mid-op: RST asserted in RD1 -> next cycle IDLE, all strobes high, no DONE.
REQ-037 Back-to-back: START held high across two shifter ops with SHIFT_OP_IN changing in RD0 -> second accepted only from IDLE after FIN, SHIFTER_OP reflects value at each accept.
REQ-038 Random 10k cycles: REQ-026 invariant assertion never fails.
